// File: rtl/fetch_branch_unit.sv
// ============================================================================
// Module      : fetch_branch_unit
// Description : Instruction fetch handshake plus branch decode for the PC
//               block. Optional fetch timeout via macro FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_branch_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pc,
    input  logic       zero_flag,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] pc_control,
    output logic [7:0] jump_offset,
    output logic       pc_en,
    output logic [7:0] instr,
    output logic       instr_valid
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic       fetch_err
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("fetch_branch_unit: TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    logic [1:0] r_state;
    logic       r_req;
    logic [7:0] r_addr;
    logic [7:0] r_pc_control;
    logic [7:0] r_jump_offset;
    logic       r_pc_en;
    logic [7:0] r_instr;
    logic       r_instr_valid;

    logic       w_ack;
    logic       w_timeout;
    logic       w_is_branch;
    logic       w_taken;
    logic [7:0] w_offset;

    // A response only counts while our request is outstanding.
    assign w_ack       = imem_ack & r_req;
    assign w_is_branch = (r_instr[7:6] == 2'b11);
    assign w_taken     = w_is_branch & (~r_instr[5] | zero_flag);
    assign w_offset    = w_is_branch ? {{3{r_instr[4]}}, r_instr[4:0]} : 8'h00;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] c_TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tcnt;
    logic       r_fetch_err;

    // Trips on the TIMEOUT_CYCLES-th FETCH cycle without ack; ack wins a tie.
    assign w_timeout = (r_state == S_FETCH) & ~w_ack & (r_tcnt == c_TCNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt      <= 8'h00;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= w_timeout;
            if (r_state == S_FETCH && !w_ack && !w_timeout) begin
                r_tcnt <= r_tcnt + 8'd1;
            end else begin
                r_tcnt <= 8'h00;
            end
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_addr        <= 8'h00;
            r_pc_control  <= 8'h00;
            r_jump_offset <= 8'h00;
            r_pc_en       <= 1'b0;
            r_instr       <= 8'h00;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc_en       <= 1'b0;
            r_instr_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= pc;
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_instr <= imem_data;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        // Substitute a NOP so the PC still advances by one.
                        r_instr <= 8'h00;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_pc_control  <= w_taken ? 8'hFF : 8'h00;
                    r_jump_offset <= w_offset;
                    r_pc_en       <= 1'b1;
                    r_instr_valid <= 1'b1;
                    r_state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= pc;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign pc_control  = r_pc_control;
    assign jump_offset = r_jump_offset;
    assign pc_en       = r_pc_en;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_branch_unit.sv
// ============================================================================
// Module      : tb_fetch_branch_unit
// Description : Directed self-checking bench for fetch_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_branch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] pc;
    logic       zero_flag;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] pc_control;
    logic [7:0] jump_offset;
    logic       pc_en;
    logic [7:0] instr;
    logic       instr_valid;
`ifdef FETCH_TIMEOUT_EN
    logic       fetch_err;
`endif

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_addr;

    fetch_branch_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .zero_flag   (zero_flag),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .pc_control  (pc_control),
        .jump_offset (jump_offset),
        .pc_en       (pc_en),
        .instr       (instr),
        .instr_valid (instr_valid)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err   (fetch_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    {7'd0, imem_req},    8'h00);
        chk({tag, "_addr"},   imem_addr,           8'h00);
        chk({tag, "_pcctl"},  pc_control,          8'h00);
        chk({tag, "_joff"},   jump_offset,         8'h00);
        chk({tag, "_pcen"},   {7'd0, pc_en},       8'h00);
        chk({tag, "_instr"},  instr,               8'h00);
        chk({tag, "_ivalid"}, {7'd0, instr_valid}, 8'h00);
    endtask

    // Entered at the start of a FETCH cycle; leaves at the start of the next one.
    task automatic do_fetch(input logic [7:0] data, input logic zf, input int delay,
                            input logic [7:0] exp_ctl, input logic [7:0] exp_jo,
                            input logic [7:0] next_pc);
        chk("fetch_req", {7'd0, imem_req}, 8'h01);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("hold_req", {7'd0, imem_req}, 8'h01);
            chk("hold_addr", imem_addr, exp_addr);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
        imem_data = 8'hAA;
        zero_flag = zf;
        chk("dec_req", {7'd0, imem_req}, 8'h00);
        chk("dec_instr", instr, data);
        chk("dec_pcen", {7'd0, pc_en}, 8'h00);
        tick();
        chk("iss_pcen", {7'd0, pc_en}, 8'h01);
        chk("iss_ivalid", {7'd0, instr_valid}, 8'h01);
        chk("iss_pcctl", pc_control, exp_ctl);
        chk("iss_joff", jump_offset, exp_jo);
        zero_flag = ~zf;
        pc        = next_pc;
        exp_addr  = next_pc;
        tick();
        chk("post_pcen", {7'd0, pc_en}, 8'h00);
        chk("post_ivalid", {7'd0, instr_valid}, 8'h00);
        chk("post_pcctl_hold", pc_control, exp_ctl);
        chk("post_joff_hold", jump_offset, exp_jo);
    endtask

    initial begin
        rst       = 1'b1;
        pc        = 8'h33;
        zero_flag = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        exp_addr  = 8'h00;
        tick();
        tick();
        chk_reset("reset");

        pc       = 8'h20;
        exp_addr = 8'h20;
        rst      = 1'b0;
        tick();

        do_fetch(8'hC3, 1'b0, 0, 8'hFF, 8'h03, 8'h21);
        do_fetch(8'hFE, 1'b1, 1, 8'hFF, 8'hFE, 8'h22);
        do_fetch(8'hFE, 1'b0, 0, 8'h00, 8'hFE, 8'h23);
        do_fetch(8'h42, 1'b0, 2, 8'h00, 8'h00, 8'h24);
        do_fetch(8'hDF, 1'b0, 0, 8'hFF, 8'hFF, 8'h25);
        do_fetch(8'h9F, 1'b1, 0, 8'h00, 8'h00, 8'h26);
        do_fetch(8'hE0, 1'b0, 0, 8'h00, 8'h00, 8'h10);

        // Slow fetch at 0x10, then reset with an ack colliding on the reset edge.
        chk("slow_req", {7'd0, imem_req}, 8'h01);
        chk("slow_addr", imem_addr, 8'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slow_hold_req", {7'd0, imem_req}, 8'h01);
            chk("slow_hold_addr", imem_addr, 8'h10);
        end
        rst       = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 8'hC3;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        pc  = 8'h40;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 8'h00);
        chk("late_ack_pcen", {7'd0, pc_en}, 8'h00);
        exp_addr = 8'h40;
        do_fetch(8'h42, 1'b0, 0, 8'h00, 8'h00, 8'h41);

`ifdef FETCH_TIMEOUT_EN
        chk("to_err_idle", {7'd0, fetch_err}, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("to_req_still", {7'd0, imem_req}, 8'h01);
        chk("to_err_early", {7'd0, fetch_err}, 8'h00);
        tick();
        chk("to_err_pulse", {7'd0, fetch_err}, 8'h01);
        chk("to_req_drop", {7'd0, imem_req}, 8'h00);
        chk("to_instr_nop", instr, 8'h00);
        tick();
        chk("to_err_clear", {7'd0, fetch_err}, 8'h00);
        chk("to_pcen", {7'd0, pc_en}, 8'h01);
        chk("to_pcctl", pc_control, 8'h00);
        pc = 8'h50;
        tick();
        chk("tie_addr", imem_addr, 8'h50);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        imem_ack  = 1'b1;
        imem_data = 8'hC3;
        tick();
        imem_ack = 1'b0;
        chk("tie_err", {7'd0, fetch_err}, 8'h00);
        chk("tie_instr", instr, 8'hC3);
        chk("tie_req", {7'd0, imem_req}, 8'h00);
        tick();
        chk("tie_pcen", {7'd0, pc_en}, 8'h01);
        chk("tie_pcctl", pc_control, 8'hFF);
        chk("tie_joff", jump_offset, 8'h03);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
